// File: rtl/ahb_master_if.sv
// AHB-Lite single-transfer initiator: bridges a core request/response port onto the bus.
// Address and data phases are pipelined; HREADY stalls both; ERROR cancels the queued address.
module ahb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [1:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned TRANS_W = 2;
  localparam int unsigned BURST_W = 3;

  localparam logic [TRANS_W-1:0] TRANS_IDLE   = 2'b00;
  localparam logic [TRANS_W-1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [BURST_W-1:0] BURST_SINGLE = 3'b000;

  // Error sequencer: ERR = waiting for the completing cycle, ERR_CANCEL additionally owes a
  // response for the cancelled address phase, CANCEL_RSP emits that owed response.
  typedef enum logic [1:0] {
    ST_RUN,
    ST_ERR,
    ST_ERR_CANCEL,
    ST_CANCEL_RSP
  } err_state_t;

  err_state_t state, state_nxt;

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [SIZE_W-1:0] a_size;
  logic [DATA_W-1:0] a_wdata;

  logic              d_valid;
  logic              d_we;
  logic [DATA_W-1:0] hwdata_q;

  logic err_start;
  logic err_blk;
  logic cancel_pend;
  logic cancel_a;
  logic cancel_rsp;

  // First cycle of a two-cycle ERROR response on an active data phase
  assign err_start = d_valid & HRESP & ~HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    err_blk     = 1'b0;
    cancel_pend = 1'b0;
    cancel_a    = 1'b0;
    cancel_rsp  = 1'b0;
    case (state)
      ST_RUN: begin
        if (err_start) begin
          cancel_a  = a_valid;
          state_nxt = a_valid ? ST_ERR_CANCEL : ST_ERR;
        end
      end
      ST_ERR: begin
        err_blk = 1'b1;
        if (HREADY) begin
          state_nxt = ST_RUN;
        end else if (err_start && a_valid) begin
          cancel_a  = 1'b1;
          state_nxt = ST_ERR_CANCEL;
        end
      end
      ST_ERR_CANCEL: begin
        err_blk     = 1'b1;
        cancel_pend = 1'b1;
        if (HREADY) begin
          state_nxt = ST_CANCEL_RSP;
        end
      end
      ST_CANCEL_RSP: begin
        cancel_pend = 1'b1;
        cancel_rsp  = 1'b1;
        state_nxt   = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign cpu_gnt = cpu_req & (~a_valid | HREADY) & ~err_blk & ~cancel_pend;

  // Address phase stage
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_we    <= 1'b0;
      a_size  <= '0;
      a_wdata <= '0;
    end else if (cpu_gnt) begin
      a_valid <= 1'b1;
      a_addr  <= cpu_addr;
      a_we    <= cpu_we;
      a_size  <= cpu_size;
      a_wdata <= cpu_wdata;
    end else if (HREADY || cancel_a) begin
      a_valid <= 1'b0;
    end
  end

  // Data phase stage; write data follows its address one cycle later
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid  <= 1'b0;
      d_we     <= 1'b0;
      hwdata_q <= '0;
    end else if (HREADY) begin
      d_valid <= a_valid;
      d_we    <= a_we;
      if (a_valid) begin
        hwdata_q <= a_wdata;
      end
    end
  end

  // Core response: one pulse per completed or cancelled transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
    end else if (d_valid && HREADY) begin
      cpu_rvalid <= 1'b1;
      cpu_err    <= HRESP;
      cpu_rdata  <= (d_we || HRESP) ? '0 : HRDATA;
    end else if (cancel_rsp) begin
      cpu_rvalid <= 1'b1;
      cpu_err    <= 1'b1;
      cpu_rdata  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
    end
  end

  assign HTRANS = a_valid ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR  = a_addr;
  assign HWRITE = a_we;
  assign HSIZE  = a_size;
  assign HBURST = BURST_SINGLE;
  assign HWDATA = hwdata_q;

endmodule
